codificador_2de5: RTL and testbench
===================================

Name: codificador_2de5

Overview:
- Registered BCD-to-2-out-of-5 encoder (weights 7-4-2-1-0, POSTNET style).
- Samples a 4-bit BCD digit {a,b,c,d} when `ready` is high.
- Drives a registered 5-bit code on m1..m5 (m1 is the weight-7 bit), plus valid and error flags.
- Leaf block feeding downstream serialisers/displays in the TP1 datapath.

Parameters:
- none (code table fixed; see Decomposition)

Ports:
- clk    input   1  system clock, rising-edge active
- reset  input   1  asynchronous, active-high reset
- a      input   1  BCD digit bit 3 (MSB)
- b      input   1  BCD digit bit 2
- c      input   1  BCD digit bit 1
- d      input   1  BCD digit bit 0 (LSB)
- ready  input   1  sample enable; digit captured on a clk edge where ready=1
- m1     output  1  code bit, weight 7
- m2     output  1  code bit, weight 4
- m3     output  1  code bit, weight 2
- m4     output  1  code bit, weight 1
- m5     output  1  code bit, weight 0 (parity-like fill)
- valid  output  1  one-cycle pulse: new code presented this cycle
- err    output  1  last sampled digit was invalid (>9); sticky until the next sample

Behaviour:
- Reset (async assert, any time): m1..m5=00000, valid=0, err=0. Deassertion is synchronised by the user; the first active edge after deassertion behaves normally.
- Digit D = {a,b,c,d}, a is the MSB.
- On rising clk with ready=1: D is encoded and registered. Latency is 1 cycle: outputs update at the same edge that samples.
- On that edge valid=1. On the next edge valid=0 unless ready is still 1.
- Back-to-back samples: ready held high samples every cycle, and valid stays 1 every cycle.
- ready=0: m1..m5 and err hold their last values; valid=0.
- Code table for D, giving m1m2m3m4m5:
  - 0 -> 11000
  - 1 -> 00011
  - 2 -> 00101
  - 3 -> 00110
  - 4 -> 01001
  - 5 -> 01010
  - 6 -> 01100
  - 7 -> 10001
  - 8 -> 10010
  - 9 -> 10100
- Invariant: every valid code has exactly two 1s. The weighted sum of bits equals D, except D=0, which uses 7+4.
- Invalid D (10..15) with ready=1: m1..m5=00000, err=1, valid=1.
- Next valid sample clears err.
- Inputs X/Z are not handled; the bench drives known values.
- Reset mid-operation: outputs clear immediately (asynchronous), and no valid pulse is emitted on the edge after release unless ready=1.
- No internal FSM beyond output registers; purely encode-and-hold.

Decomposition:
- Shared package codificador_pkg:
  - 5-bit code constants CODE_0..CODE_9.
  - CODE_INVALID = 5'b00000.
  - Function/localparam BCD_MAX = 9.
- One combinational sub-module bcd_to_2de5:
  - Input: 4-bit D.
  - Outputs: 5-bit code and invalid flag.
  - The top module holds only the registers, valid pulse and err.

Test Plan:
- reset=1 for 1 cycle, ready=0 -> m=00000, valid=0, err=0; asserting reset between edges clears outputs without waiting for clk.
- Sweep D=0..9 with ready=1 for one cycle each (0000 ... 1001), matching the truth-table order -> after each edge m equals the table (e.g. 0000->11000, 0001->00011, 0111->10001, 1001->10100), valid=1, err=0, popcount(m)=2.
- D=1010 and D=1111 with ready=1 -> m=00000, err=1, valid=1; then D=0101 -> m=01010, err=0.
- Sample D=0011, then ready=0 and change D to 1000 for 3 cycles -> m holds 00110, valid=0.
- ready held high while D steps 4,5,6 on consecutive cycles -> m = 01001, 01010, 01100 on successive cycles, with valid=1 continuously.
- Reset asserted while ready=1 and D=0010 -> m=00000 immediately; after release with ready=1, the next edge gives m=00101.

Source files
------------

// File: rtl/codificador_2de5_pkg.sv
// Shared constants for the BCD to 2-out-of-5 (7-4-2-1-0) encoder.
// Code bit order is {m1,m2,m3,m4,m5}; m1 carries weight 7.
package codificador_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [4:0] CODE_0       = 5'b11000;
    localparam logic [4:0] CODE_1       = 5'b00011;
    localparam logic [4:0] CODE_2       = 5'b00101;
    localparam logic [4:0] CODE_3       = 5'b00110;
    localparam logic [4:0] CODE_4       = 5'b01001;
    localparam logic [4:0] CODE_5       = 5'b01010;
    localparam logic [4:0] CODE_6       = 5'b01100;
    localparam logic [4:0] CODE_7       = 5'b10001;
    localparam logic [4:0] CODE_8       = 5'b10010;
    localparam logic [4:0] CODE_9       = 5'b10100;
    localparam logic [4:0] CODE_INVALID = 5'b00000;

endpackage

// File: rtl/codificador_2de5_if.sv
// Digit-in / code-out bundle of the encoder.
// The master drives the digit and ready; the slave returns the code and flags.
interface codificador_2de5_if;

    logic a;
    logic b;
    logic c;
    logic d;
    logic ready;
    logic m1;
    logic m2;
    logic m3;
    logic m4;
    logic m5;
    logic valid;
    logic err;

    modport master (
        output a, b, c, d, ready,
        input  m1, m2, m3, m4, m5, valid, err
    );

    modport slave (
        input  a, b, c, d, ready,
        output m1, m2, m3, m4, m5, valid, err
    );

endinterface

// File: rtl/codificador_2de5_bcd.sv
// Combinational BCD digit to 2-out-of-5 code lookup.
// Digits above 9 give the all-zero code and raise o_invalid.
module bcd_to_2de5
    import codificador_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [4:0] o_code,
    output logic       o_invalid
);

    always_comb begin
        o_code    = CODE_INVALID;
        o_invalid = (i_digit > BCD_MAX);
        case (i_digit)
            4'd0:    o_code = CODE_0;
            4'd1:    o_code = CODE_1;
            4'd2:    o_code = CODE_2;
            4'd3:    o_code = CODE_3;
            4'd4:    o_code = CODE_4;
            4'd5:    o_code = CODE_5;
            4'd6:    o_code = CODE_6;
            4'd7:    o_code = CODE_7;
            4'd8:    o_code = CODE_8;
            4'd9:    o_code = CODE_9;
            default: o_code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/codificador_2de5.sv
// Registered BCD to 2-out-of-5 encoder: samples the digit when ready is high,
// holds code and err otherwise, and pulses valid on every sampling edge.
module codificador_2de5
    import codificador_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    codificador_2de5_if.slave   bus
);

    logic [3:0] w_digit;
    logic [4:0] w_code;
    logic       w_invalid;

    logic [4:0] r_code;
    logic       r_valid;
    logic       r_err;

    assign w_digit = {bus.a, bus.b, bus.c, bus.d};

    bcd_to_2de5 u_lookup (
        .i_digit   (w_digit),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    // Code and err only move on a sample; valid is recomputed every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code  <= CODE_INVALID;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= bus.ready;
            if (bus.ready) begin
                r_code <= w_code;
                r_err  <= w_invalid;
            end
        end
    end

    assign bus.m1    = r_code[4];
    assign bus.m2    = r_code[3];
    assign bus.m3    = r_code[2];
    assign bus.m4    = r_code[1];
    assign bus.m5    = r_code[0];
    assign bus.valid = r_valid;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_codificador_2de5.sv
// Directed scoreboard bench for codificador_2de5: expected {code,valid,err}
// is queued when a digit is driven and compared one edge later.
module tb_codificador_2de5;

    typedef struct packed {
        logic [4:0] m;
        logic       v;
        logic       e;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    codificador_2de5_if bus ();

    codificador_2de5 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    exp_t       mdl;
    exp_t       got_exp;
    int         checks   = 0;
    int         failures = 0;
    logic [4:0] tbl [10];

    function automatic logic [6:0] observed();
        return {bus.m1, bus.m2, bus.m3, bus.m4, bus.m5, bus.valid, bus.err};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one digit on the falling edge, predict, then compare after the rising edge.
    task automatic drive(input logic [3:0] dv, input logic rdy);
        logic [4:0] m_obs;
        @(negedge clk);
        {bus.a, bus.b, bus.c, bus.d} = dv;
        bus.ready = rdy;
        if (rdy) begin
            if (dv <= 4'd9) begin
                mdl.m = tbl[dv];
                mdl.e = 1'b0;
            end else begin
                mdl.m = 5'b00000;
                mdl.e = 1'b1;
            end
        end
        mdl.v = rdy;
        q.push_back(mdl);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got_exp = q.pop_front();
            check($sformatf("D%0d_ready%0d", dv, rdy), observed(), got_exp);
            $display("txn D=%0d ready=%0d m=%b valid=%b err=%b", dv, rdy,
                     observed() >> 2, bus.valid, bus.err);
        end
        if (rdy && dv <= 4'd9) begin
            m_obs = {bus.m1, bus.m2, bus.m3, bus.m4, bus.m5};
            check($sformatf("popcount_D%0d", dv), 7'($countones(m_obs)), 7'd2);
        end
    endtask

    initial begin
        tbl[0] = 5'b11000; tbl[1] = 5'b00011; tbl[2] = 5'b00101;
        tbl[3] = 5'b00110; tbl[4] = 5'b01001; tbl[5] = 5'b01010;
        tbl[6] = 5'b01100; tbl[7] = 5'b10001; tbl[8] = 5'b10010;
        tbl[9] = 5'b10100;
        mdl = '0;
        {bus.a, bus.b, bus.c, bus.d} = 4'd0;
        bus.ready = 1'b0;

        // Reset held across an edge with ready low.
        @(posedge clk);
        #1;
        check("reset_state", observed(), 7'b0000000);
        @(negedge clk);
        reset = 1'b0;
        drive(4'd0, 1'b0);

        // Sweep valid digits, one sample each.
        for (int i = 0; i < 10; i++) drive(4'(i), 1'b1);

        // Invalid digits, then recovery.
        drive(4'd10, 1'b1);
        drive(4'd15, 1'b1);
        drive(4'd5,  1'b1);

        // Hold with ready low while the digit changes.
        drive(4'd3, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'd8, 1'b0);

        // Back-to-back samples.
        drive(4'd4, 1'b1);
        drive(4'd5, 1'b1);
        drive(4'd6, 1'b1);

        // Asynchronous reset between edges with ready high and D=2.
        drive(4'd9, 1'b1);
        @(negedge clk);
        {bus.a, bus.b, bus.c, bus.d} = 4'd2;
        bus.ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", observed(), 7'b0000000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", observed(), 7'b0000000);
        mdl = '0;
        @(negedge clk);
        reset = 1'b0;
        drive(4'd2, 1'b1);

        // Reset release with ready low yields no valid pulse.
        @(negedge clk);
        reset = 1'b1;
        bus.ready = 1'b0;
        #1;
        check("async_reset_second", observed(), 7'b0000000);
        mdl = '0;
        @(negedge clk);
        reset = 1'b0;
        drive(4'd7, 1'b0);
        drive(4'd7, 1'b1);

        if (q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
